// File: rtl/wb_stage_if.sv
// MEM->WB handshake and register-file write port bundle for wb_stage.
// master = MEM-side driver / regfile observer, slave = the write-back stage.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              freeze;
    logic              flush;
    logic              in_valid;
    logic              in_wb_en;
    logic              in_mem_r_en;
    logic [4:0]        in_dest;
    logic [DATA_W-1:0] in_alu_res;
    logic [DATA_W-1:0] in_mem_data;
    logic              in_mem_ready;
    logic              Write_EN;
    logic [4:0]        dest;
    logic [DATA_W-1:0] Write_Val;
    logic              stall_req;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output freeze, flush, in_valid, in_wb_en, in_mem_r_en, in_dest,
               in_alu_res, in_mem_data, in_mem_ready,
        input  Write_EN, dest, Write_Val, stall_req, retire_cnt
    );

    modport slave (
        input  freeze, flush, in_valid, in_wb_en, in_mem_r_en, in_dest,
               in_alu_res, in_mem_data, in_mem_ready,
        output Write_EN, dest, Write_Val, stall_req, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, load/ALU select, late-load wait, R0 suppression.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic      clk,
    input  logic      rst,
    wb_stage_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        VALID     = 2'd1,
        WAIT_LOAD = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_wb_en;
    logic [4:0]        r_dest;
    logic [DATA_W-1:0] r_data;
    logic              r_wr_en;

    logic w_capture;
    logic w_take;
    logic w_late_load;
    logic w_load_done;
    logic w_retire;

    // WAIT_LOAD ignores freeze and flush; it only listens to in_mem_ready.
    assign w_capture   = (r_state != WAIT_LOAD) && !bus.freeze;
    assign w_take      = w_capture && !bus.flush && bus.in_valid;
    assign w_late_load = w_take && bus.in_mem_r_en && !bus.in_mem_ready;
    assign w_load_done = (r_state == WAIT_LOAD) && bus.in_mem_ready;

    // First VALID cycle of an entry that actually writes a non-R0 register.
    assign w_retire = (w_take && !w_late_load && bus.in_wb_en && (bus.in_dest != 5'd0))
                   || (w_load_done && r_wb_en && (r_dest != 5'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_wb_en <= 1'b0;
            r_dest  <= 5'd0;
            r_data  <= '0;
            r_wr_en <= 1'b0;
        end else begin
            if (w_load_done) begin
                r_state <= VALID;
                r_data  <= bus.in_mem_data;
            end else if (w_capture) begin
                if (!w_take) begin
                    r_state <= EMPTY;
                    r_wb_en <= 1'b0;
                end else begin
                    r_wb_en <= bus.in_wb_en;
                    r_dest  <= bus.in_dest;
                    if (w_late_load) begin
                        r_state <= WAIT_LOAD;
                    end else begin
                        r_state <= VALID;
                        r_data  <= bus.in_mem_r_en ? bus.in_mem_data : bus.in_alu_res;
                    end
                end
            end
            // Held VALID under freeze keeps re-issuing the same idempotent write.
            r_wr_en <= w_retire || (r_wr_en && !w_capture);
        end
    end

    assign bus.Write_EN  = r_wr_en;
    assign bus.dest      = r_dest;
    assign bus.Write_Val = r_data;
    assign bus.stall_req = (r_state == WAIT_LOAD);

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_retire_cnt <= '0;
        else if (w_retire)
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end

    assign bus.retire_cnt = r_retire_cnt;
`else
    assign bus.retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: write scoreboard popped on every Write_EN cycle,
// plus per-scenario checks of stall, R0 suppression, freeze/flush and async reset.
module tb_wb_stage;
    localparam int DW = 32;
    localparam int CW = 32;

    typedef struct packed {
        logic [4:0]    d;
        logic [DW-1:0] v;
    } wr_t;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    int      errors = 0;
    int      checks = 0;
    wr_t     exp_q[$];
    wr_t     mon_e;
    logic [CW-1:0] exp_cnt = '0;

    wb_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus();

    wb_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Every write the regfile would see must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.Write_EN === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got dest=%0d val=%h, none expected",
                         bus.dest, bus.Write_Val);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.dest, bus.Write_Val} !== mon_e) begin
                    errors++;
                    $display("FAIL write_data: got dest=%0d val=%h want dest=%0d val=%h",
                             bus.dest, bus.Write_Val, mon_e.d, mon_e.v);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.freeze       = 1'b0;
        bus.flush        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_wb_en     = 1'b0;
        bus.in_mem_r_en  = 1'b0;
        bus.in_dest      = 5'd0;
        bus.in_alu_res   = '0;
        bus.in_mem_data  = '0;
        bus.in_mem_ready = 1'b0;
    endtask

    task automatic drive(input logic ld, input logic [4:0] d, input logic [DW-1:0] alu,
                         input logic [DW-1:0] md, input logic rdy);
        bus.in_valid     = 1'b1;
        bus.in_wb_en     = 1'b1;
        bus.in_mem_r_en  = ld;
        bus.in_dest      = d;
        bus.in_alu_res   = alu;
        bus.in_mem_data  = md;
        bus.in_mem_ready = rdy;
    endtask

    task automatic push_wr(input logic [4:0] d, input logic [DW-1:0] v);
        exp_q.push_back({d, v});
    endtask

    task automatic bump();
`ifdef WB_RETIRE_CNT_EN
        exp_cnt = exp_cnt + CW'(1);
`endif
    endtask

    task automatic test_reset();
        idle();
        #2 rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if ({bus.Write_EN, bus.dest, bus.Write_Val, bus.stall_req, bus.retire_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got we=%b dest=%0d val=%h stall=%b cnt=%0d want all 0",
                     bus.Write_EN, bus.dest, bus.Write_Val, bus.stall_req, bus.retire_cnt);
        end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_alu();
        drive(1'b0, 5'd5, 32'h1234, 32'h0, 1'b0);
        push_wr(5'd5, 32'h1234);
        bump();
        cyc();
        idle();
        @(negedge clk);
        checks++;
        if (bus.Write_EN !== 1'b1 || bus.retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL alu_write: got we=%b cnt=%0d want we=1 cnt=%0d",
                     bus.Write_EN, bus.retire_cnt, exp_cnt);
        end
        cyc();
    endtask

    task automatic test_r0();
        drive(1'b0, 5'd0, 32'hFFFF, 32'h0, 1'b0);
        cyc();
        idle();
        @(negedge clk);
        checks++;
        if (bus.Write_EN !== 1'b0 || bus.retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL r0_suppress: got we=%b cnt=%0d want we=0 cnt=%0d",
                     bus.Write_EN, bus.retire_cnt, exp_cnt);
        end
        cyc();
    endtask

    task automatic test_late_load();
        drive(1'b1, 5'd8, 32'h100, 32'h0, 1'b0);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.stall_req !== 1'b1 || bus.Write_EN !== 1'b0) begin
                errors++;
                $display("FAIL load_wait[%0d]: got stall=%b we=%b want stall=1 we=0",
                         i, bus.stall_req, bus.Write_EN);
            end
            if (i == 2) begin
                bus.in_mem_ready = 1'b1;
                bus.in_mem_data  = 32'hDEADBEEF;
                push_wr(5'd8, 32'hDEADBEEF);
                bump();
            end
            cyc();
        end
        idle();
        @(negedge clk);
        checks++;
        if (bus.Write_EN !== 1'b1 || bus.stall_req !== 1'b0 || bus.retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL load_done: got we=%b stall=%b cnt=%0d want we=1 stall=0 cnt=%0d",
                     bus.Write_EN, bus.stall_req, bus.retire_cnt, exp_cnt);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (bus.Write_EN !== 1'b0) begin
            errors++;
            $display("FAIL load_one_cycle: got we=%b want 0", bus.Write_EN);
        end
        cyc();
    endtask

    task automatic test_freeze();
        drive(1'b0, 5'd3, 32'd7, 32'h0, 1'b0);
        bump();
        for (int i = 0; i < 5; i++) push_wr(5'd3, 32'd7);
        cyc();
        idle();
        bus.freeze = 1'b1;
        repeat (4) cyc();
        bus.freeze = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.Write_EN !== 1'b1 || bus.retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL freeze_hold: got we=%b cnt=%0d want we=1 cnt=%0d",
                     bus.Write_EN, bus.retire_cnt, exp_cnt);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (bus.Write_EN !== 1'b0 || bus.retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL freeze_release: got we=%b cnt=%0d want we=0 cnt=%0d",
                     bus.Write_EN, bus.retire_cnt, exp_cnt);
        end
    endtask

    task automatic test_flush();
        drive(1'b0, 5'd9, 32'h55, 32'h0, 1'b0);
        push_wr(5'd9, 32'h55);
        bump();
        cyc();
        // freeze + flush: the dest=9 entry must survive and write again
        drive(1'b0, 5'd10, 32'h66, 32'h0, 1'b0);
        bus.flush  = 1'b1;
        bus.freeze = 1'b1;
        push_wr(5'd9, 32'h55);
        cyc();
        bus.freeze = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.dest !== 5'd9 || bus.Write_Val !== 32'h55) begin
            errors++;
            $display("FAIL flush_freeze: got dest=%0d val=%h want dest=9 val=55",
                     bus.dest, bus.Write_Val);
        end
        cyc();
        idle();
        @(negedge clk);
        checks++;
        if (bus.Write_EN !== 1'b0 || bus.retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL flush_bubble: got we=%b cnt=%0d want we=0 cnt=%0d",
                     bus.Write_EN, bus.retire_cnt, exp_cnt);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [4:0]    d;
        logic [DW-1:0] v;
        logic          ld;
        for (int i = 0; i < 8; i++) begin
            d  = 5'($urandom_range(0, 31));
            v  = $urandom;
            ld = (i % 3 == 2);
            if (i == 4) d = 5'd0;
            drive(ld, d, v, ~v, 1'b1);
            if (d != 5'd0) begin
                push_wr(d, ld ? ~v : v);
                bump();
            end
            cyc();
        end
        idle();
        @(negedge clk);
        checks++;
        if (bus.retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_count: got cnt=%0d want %0d", bus.retire_cnt, exp_cnt);
        end
        cyc();
    endtask

    task automatic test_reset_wait();
        drive(1'b1, 5'd12, 32'h200, 32'h0, 1'b0);
        cyc();
        idle();
        @(negedge clk);
        checks++;
        if (bus.stall_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_pre: got stall=%b want 1", bus.stall_req);
        end
        #2 rst = 1'b1;
        exp_cnt = '0;
        #1;
        checks++;
        if ({bus.Write_EN, bus.dest, bus.Write_Val, bus.stall_req, bus.retire_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_async: got we=%b dest=%0d val=%h stall=%b cnt=%0d want all 0",
                     bus.Write_EN, bus.dest, bus.Write_Val, bus.stall_req, bus.retire_cnt);
        end
        cyc();
        rst = 1'b0;
        bus.in_mem_ready = 1'b1;
        bus.in_mem_data  = 32'hCAFEF00D;
        cyc();
        idle();
        @(negedge clk);
        checks++;
        if (bus.Write_EN !== 1'b0 || bus.stall_req !== 1'b0 || bus.retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL rst_drop_load: got we=%b stall=%b cnt=%0d want 0 0 %0d",
                     bus.Write_EN, bus.stall_req, bus.retire_cnt, exp_cnt);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_r0();
        test_late_load();
        test_freeze();
        test_flush();
        test_back_to_back();
        test_reset_wait();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending writes want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
